// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream
// sources. Each grant is prefixed with a tag byte (HDR_BASE | owner index).
// The grant is released at end of message, at MAXLEN bytes, or after the
// owner has been idle for STALL_TIMEOUT consecutive cycles.
module uart_tx_arbiter #(
  parameter int         NREQ          = 4,
  parameter int         MAXLEN        = 64,
  parameter int         STALL_TIMEOUT = 1000,
  parameter logic [7:0] HDR_BASE      = 8'hA0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              stall_abort
);

  localparam int SCW = $clog2(STALL_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]     state;
  logic [2:0]     rr_ptr;
  logic [2:0]     gnt;
  logic [7:0]     byte_cnt;
  logic [SCW-1:0] stall_cnt;

  logic           cur_valid;
  logic           cur_last;
  logic [7:0]     cur_data;
  logic           any_req;
  logic [2:0]     win;
  logic [2:0]     win_next;
  logic           len_hit;
  logic           stall_hit;

  // Select the current owner's byte stream
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == 3'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[8*i +: 8];
      end
    end
  end

  // First requesting index scanning upward from rr_ptr, wrapping at NREQ
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    win     = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!any_req && (j == idx) && req_valid[j]) begin
          any_req = 1'b1;
          win     = 3'(j);
        end
      end
    end
    win_next = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
  end

  assign len_hit   = (int'(byte_cnt) + 1) >= MAXLEN;
  assign stall_hit = (int'(stall_cnt) + 1) >= STALL_TIMEOUT;

  // Grant FSM with byte and stall counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      rr_ptr      <= 3'd0;
      gnt         <= 3'd0;
      byte_cnt    <= 8'd0;
      stall_cnt   <= '0;
      stall_abort <= 1'b0;
    end else begin
      stall_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt       <= win;
            rr_ptr    <= win_next;
            byte_cnt  <= 8'd0;
            stall_cnt <= '0;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_ready) state <= S_DATA;
        end
        S_DATA: begin
          if (cur_valid && tx_ready) begin
            byte_cnt  <= byte_cnt + 8'd1;
            stall_cnt <= '0;
            if (cur_last || len_hit) begin
              state <= S_IDLE;
              gnt   <= 3'd0;
            end
          end else if (!cur_valid) begin
            if (stall_hit) begin
              state       <= S_IDLE;
              gnt         <= 3'd0;
              stall_cnt   <= '0;
              stall_abort <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 3'd0;
        end
      endcase
    end
  end

  // Output steering: tag in HDR, zero-latency pass-through in DATA
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'd0;
    req_ready = '0;
    case (state)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BASE | {5'd0, gnt};
      end
      S_DATA: begin
        tx_valid = cur_valid;
        tx_data  = cur_data;
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = (gnt == 3'(i)) && tx_ready;
        end
      end
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  assign busy     = (state == S_HDR) || (state == S_DATA);
  assign grant_id = gnt;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board UART transmitter (the one driving rs232_SOUT) between NREQ byte-stream requesters, e.g. the Ethernet RX sniffer, LED/status reporter and debug dumper.
- Arbitrates round-robin on message boundaries. Each granted message is prefixed with a one-byte tag identifying the source.
- Forces release on over-length messages or stalled requesters, so no single source can hog the link.
- Sits in the CLK_MAIN domain between the requesters and the UART TX valid/ready interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXLEN, 64, maximum data bytes per grant (1..255).
- STALL_TIMEOUT, 1000, consecutive cycles with granted req_valid low before forced release (>=1).
- HDR_BASE, 8'hA0, tag byte base; emitted tag = HDR_BASE | grant index (low 3 bits of HDR_BASE must be zero).

Ports:
- CLK  in  1  main clock.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  marks final byte of a message; qualified by req_valid.
- req_ready  out  NREQ  per-requester byte accepted.
- tx_valid  out  1  byte to UART transmitter valid.
- tx_data  out  8  byte to UART transmitter.
- tx_ready  in  1  UART transmitter can accept.
- grant_id  out  3  index of current owner; 0 when idle.
- busy  out  1  high in HDR or DATA.
- stall_abort  out  1  one-cycle pulse on timeout release.

Behaviour:
- Handshake: a transfer occurs on any cycle with valid && ready. tx_valid is never dropped without a transfer except on reset or forced release.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, tx_valid=0, tx_data=0, req_ready=0, stall_abort=0, byte_cnt=0, stall_cnt=0.
- Reset mid-operation abandons the message; no tag or data is emitted afterwards until a new arbitration.
- IDLE:
  - tx_valid=0, req_ready=0.
  - If any req_valid is set, the winner is the first index i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Next cycle: grant_id<=i, rr_ptr<=(i+1) mod NREQ, byte_cnt<=0, stall_cnt<=0, state<=HDR.
  - Latency from req_valid rising to tx_valid: 1 cycle.
- HDR:
  - tx_valid=1, tx_data=HDR_BASE|grant_id, req_ready=0.
  - On tx_ready: state<=DATA.
- DATA:
  - tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready. All other req_ready=0. These are combinational pass-through paths, zero latency.
  - On a transfer: byte_cnt++, stall_cnt<=0.
  - Release to IDLE when the transferred byte has req_last=1, or byte_cnt reaches MAXLEN on that transfer. Both at once count as a single release.
  - After MAXLEN truncation, the remainder of the message re-arbitrates as a new grant with a new tag.
  - Cycles with req_valid[g]=0 increment stall_cnt. Cycles where tx_ready is low and req_valid[g]=1 do not count.
  - When stall_cnt reaches STALL_TIMEOUT: release to IDLE, stall_abort=1 for one cycle, no byte transferred.
- Gap between grants: exactly one IDLE cycle. Back-to-back messages from the same sole requester get a new tag each.
- tx_ready low in any state holds the state, tx_data, and counters (except stall_cnt as above).
- A requester dropping req_valid mid-message is legal; it only feeds stall_cnt.
- busy=1 iff state is HDR or DATA. grant_id holds its value through HDR/DATA and returns to 0 in IDLE.

Test Plan:
- Req 2 sends 0x11,0x22,0x33 (last on 0x33), tx_ready=1 -> tx stream A2,11,22,33. tx_valid rises 1 cycle after req_valid. busy drops after 0x33.
- Req 0,1,3 all valid with 1-byte messages continuously -> tags in order A0,A1,A3,A0,... with one idle cycle between grants.
- MAXLEN=4, req 1 sends 6 bytes 01..06 with last on 06 -> A1,01,02,03,04, idle, A1,05,06.
- STALL_TIMEOUT=8, req 0 sends 1 byte then holds req_valid low -> release after 8 cycles, stall_abort pulses once, req 1 pending is then granted (A1).
- tx_ready toggles every other cycle during a 5-byte message -> all bytes delivered in order, no duplicates, no stall_abort.
- Assert RST during DATA after 2 bytes -> next cycle tx_valid=0, busy=0, grant_id=0. Next arbitration starts from rr_ptr=0.
